dmem_bridge: RTL and testbench

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/dmem_bridge_pkg.sv | 20 ++
 rtl/dmem_bridge_if.sv | 33 +++
 rtl/dmem_bridge_ack_timer.sv | 36 +++
 rtl/dmem_bridge.sv | 149 ++++++++++++++
 tb/tb_dmem_bridge.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge between the core and a word RAM.
// Optional alignment checking is enabled with the DMEM_BRIDGE_ALIGN_CHECK_EN macro.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    localparam logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF;
    localparam logic [31:0] MISALIGN_RDATA = 32'h0000_0000;
    localparam int          TIMER_W        = 8;

    function automatic logic is_word_aligned(input logic [1:0] byte_off);
        return (byte_off == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Core-side request/response and RAM-side signals of the data-memory bridge.
// The bridge takes the slave view; the core/RAM environment takes the master view.
interface dmem_bridge_if #(
    parameter int DEPTH_WORDS = 64
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic          req_valid;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          stall;
    logic [31:0]   rdata;
    logic          rdata_valid;
    logic          err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ack;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
        input  stall, rdata, rdata_valid, err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
        output stall, rdata, rdata_valid, err, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_bridge_ack_timer.sv
// Cycle counter bounding how long the bridge waits for a RAM acknowledge.
// expired flags the cycle in which the incremented count reaches limit.
module ack_timer
    import dmem_bridge_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic [TIMER_W-1:0] limit,
    output logic               expired
);

    logic [TIMER_W-1:0] count_r;
    logic [TIMER_W-1:0] count_next_s;

    // Next count and expiry for the current waiting cycle
    always_comb begin
        count_next_s = count_r + 8'd1;
        expired      = enable && (count_next_s == limit);
    end

    // Count register: cleared on entry to the wait, stepped each wait cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {TIMER_W{1'b0}};
        end else if (clear) begin
            count_r <= {TIMER_W{1'b0}};
        end else if (enable) begin
            count_r <= count_next_s;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Load/store bridge: captures one core request, runs one RAM access and stalls the core until DONE.
// Define DMEM_BRIDGE_ALIGN_CHECK_EN to reject misaligned addresses without touching the RAM.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int DEPTH_WORDS    = 64,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic         clk,
    input  logic         reset,
    dmem_bridge_if.slave bus
);

    localparam int                 AW            = $clog2(DEPTH_WORDS);
    localparam logic [TIMER_W-1:0] TIMEOUT_LIMIT = TIMER_W'(TIMEOUT_CYCLES);

    state_e        state_r;
    state_e        state_s;
    logic          cap_we_r;
    logic [AW-1:0] cap_addr_r;
    logic [31:0]   cap_wdata_r;
    logic [31:0]   rdata_r;
    logic          rdata_valid_r;
    logic          err_r;
    logic          mem_en_r;
    logic          mem_we_r;

    logic          capture_s;
    logic          ack_done_s;
    logic          timeout_s;
    logic          misalign_s;
    logic          timer_clear_s;
    logic          timer_en_s;
    logic          timer_expired_s;
    logic          unused_addr_s;

    // Only the word-index bits reach the RAM; the rest wrap away
    assign unused_addr_s = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};

    ack_timer u_ack_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .limit   (TIMEOUT_LIMIT),
        .expired (timer_expired_s)
    );

    // Next-state and per-cycle control decode
    always_comb begin
        state_s       = state_r;
        capture_s     = 1'b0;
        ack_done_s    = 1'b0;
        timeout_s     = 1'b0;
        misalign_s    = 1'b0;
        timer_clear_s = 1'b0;
        timer_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    capture_s = 1'b1;
`ifdef DMEM_BRIDGE_ALIGN_CHECK_EN
                    if (!is_word_aligned(bus.req_addr[1:0])) begin
                        misalign_s = 1'b1;
                        state_s    = ST_DONE;
                    end else begin
                        state_s    = ST_ISSUE;
                    end
`else
                    state_s = ST_ISSUE;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.mem_ack) begin
                    ack_done_s = 1'b1;
                    state_s    = ST_DONE;
                end else begin
                    timer_clear_s = 1'b1;
                    state_s       = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                timer_en_s = 1'b1;
                // An acknowledge in the expiry cycle still counts as a normal completion
                if (bus.mem_ack) begin
                    ack_done_s = 1'b1;
                    state_s    = ST_DONE;
                end else if (timer_expired_s) begin
                    timeout_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    state_s = ST_WAIT_ACK;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, captured request and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cap_we_r      <= 1'b0;
            cap_addr_r    <= {AW{1'b0}};
            cap_wdata_r   <= 32'h0000_0000;
            rdata_r       <= 32'h0000_0000;
            rdata_valid_r <= 1'b0;
            err_r         <= 1'b0;
            mem_en_r      <= 1'b0;
            mem_we_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            if (capture_s) begin
                cap_we_r    <= bus.req_we;
                cap_addr_r  <= bus.req_addr[AW+1:2];
                cap_wdata_r <= bus.req_wdata;
            end
            mem_en_r      <= (state_s == ST_ISSUE);
            mem_we_r      <= (state_s == ST_ISSUE) && bus.req_we;
            rdata_valid_r <= (state_s == ST_DONE);
            err_r         <= (state_s == ST_DONE) && (timeout_s || misalign_s);
            if (ack_done_s && !cap_we_r) begin
                rdata_r <= bus.mem_rdata;
            end else if (timeout_s) begin
                rdata_r <= TIMEOUT_RDATA;
            end else if (misalign_s) begin
                rdata_r <= MISALIGN_RDATA;
            end
        end
    end

    assign bus.stall       = bus.req_valid && (state_r != ST_DONE);
    assign bus.rdata       = rdata_r;
    assign bus.rdata_valid = rdata_valid_r;
    assign bus.err         = err_r;
    assign bus.mem_en      = mem_en_r;
    assign bus.mem_we      = mem_we_r;
    assign bus.mem_addr    = cap_addr_r;
    assign bus.mem_wdata   = cap_wdata_r;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: stimulus pushes expected completions, a monitor pops on rdata_valid.
module tb_dmem_bridge;

    localparam int DEPTH = 64;
    localparam int TMO   = 15;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dmem_bridge_if #(.DEPTH_WORDS(DEPTH)) bus ();

    dmem_bridge #(.DEPTH_WORDS(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard monitor: every completion must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.rdata_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_valid: got rdata_valid with rdata %h, required no completion", bus.rdata);
            end else begin
                e = sb_q.pop_front();
                check("sb_rdata", bus.rdata, e.rdata);
                check("sb_err", {31'd0, bus.err}, {31'd0, e.err});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access: request cycle, ISSUE, 'waits' WAIT_ACK cycles (ack on the last if ack_given), DONE
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rd, input int waits, input logic ack_given,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input logic [5:0] exp_maddr, input logic skip_issue, input logic keep_valid);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        @(negedge clk);
        check("req_stall", {31'd0, bus.stall}, 32'd1);
        check("req_no_mem_en", {31'd0, bus.mem_en}, 32'd0);
        if (!skip_issue) begin
            step();
            bus.mem_ack   = ack_given && (waits == 0);
            bus.mem_rdata = rd;
            @(negedge clk);
            check("issue_mem_en", {31'd0, bus.mem_en}, 32'd1);
            check("issue_mem_we", {31'd0, bus.mem_we}, {31'd0, we});
            check("issue_mem_addr", 32'(bus.mem_addr), {26'd0, exp_maddr});
            check("issue_mem_wdata", bus.mem_wdata, wdata);
            check("issue_stall", {31'd0, bus.stall}, 32'd1);
            check("issue_no_valid", {31'd0, bus.rdata_valid}, 32'd0);
            for (int i = 1; i <= waits; i++) begin
                step();
                bus.mem_ack = ack_given && (i == waits);
                @(negedge clk);
                check("wait_mem_en", {31'd0, bus.mem_en}, 32'd0);
                check("wait_mem_we", {31'd0, bus.mem_we}, 32'd0);
                check("wait_mem_wdata", bus.mem_wdata, wdata);
                check("wait_stall", {31'd0, bus.stall}, 32'd1);
                check("wait_no_valid", {31'd0, bus.rdata_valid}, 32'd0);
            end
        end
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0000_0000;
        @(negedge clk);
        check("done_valid", {31'd0, bus.rdata_valid}, 32'd1);
        check("done_stall", {31'd0, bus.stall}, 32'd0);
        check("done_mem_en", {31'd0, bus.mem_en}, 32'd0);
        step();
        if (!keep_valid) begin
            bus.req_valid = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required completion within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_0000;
        bus.req_wdata = 32'h0000_0000;
        bus.mem_rdata = 32'h0000_0000;
        bus.mem_ack   = 1'b0;
        step();
        step();
        @(negedge clk);
        check("rst_rdata", bus.rdata, 32'h0000_0000);
        check("rst_valid", {31'd0, bus.rdata_valid}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        step();
        reset = 1'b0;
        step();

        // Load, ack in ISSUE
        run_access(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 1'b1, 32'h1234_5678, 1'b0, 6'd4, 1'b0, 1'b0);
        // Store, ack on 3rd wait cycle; rdata keeps previous load value
        run_access(1'b1, 32'h0000_0008, 32'hCAFE_F00D, 32'h5555_5555, 3, 1'b1, 32'h1234_5678, 1'b0, 6'd2, 1'b0, 1'b0);
        // Load never acknowledged: timeout after 15 wait cycles
        run_access(1'b0, 32'h0000_0040, 32'h0, 32'h0, TMO, 1'b0, 32'hDEAD_BEEF, 1'b1, 6'd16, 1'b0, 1'b0);
        // Ack in the expiry cycle wins over the timeout
        run_access(1'b0, 32'h0000_0044, 32'h0, 32'h55AA_33CC, TMO, 1'b1, 32'h55AA_33CC, 1'b0, 6'd17, 1'b0, 1'b0);
`ifdef DMEM_BRIDGE_ALIGN_CHECK_EN
        run_access(1'b0, 32'h0000_0102, 32'h0, 32'h0, 0, 1'b0, 32'h0000_0000, 1'b1, 6'd0, 1'b1, 1'b0);
`else
        run_access(1'b0, 32'h0000_0102, 32'h0, 32'hA5A5_0001, 1, 1'b1, 32'hA5A5_0001, 1'b0, 6'd0, 1'b0, 1'b0);
`endif
        // Back-to-back with req_valid held through DONE; address wraps modulo 256 bytes
        run_access(1'b0, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, 0, 1'b1, 32'h0BAD_F00D, 1'b0, 6'd1, 1'b0, 1'b1);
        run_access(1'b1, 32'hFFFF_FFFC, 32'h1122_3344, 32'h0, 0, 1'b1, 32'h0BAD_F00D, 1'b0, 6'd63, 1'b0, 1'b1);
        run_access(1'b0, 32'h0000_0000, 32'h0, 32'h7654_3210, 2, 1'b1, 32'h7654_3210, 1'b0, 6'd0, 1'b0, 1'b0);

        // Reset in WAIT_ACK, then a stale ack arrives
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_0020;
        step();
        step();
        step();
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        step();
        reset         = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h9999_9999;
        @(negedge clk);
        check("rstmid_mem_en", {31'd0, bus.mem_en}, 32'd0);
        check("rstmid_valid", {31'd0, bus.rdata_valid}, 32'd0);
        check("rstmid_rdata", bus.rdata, 32'h0000_0000);
        check("rstmid_stall", {31'd0, bus.stall}, 32'd0);
        step();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("rstmid_mem_en2", {31'd0, bus.mem_en}, 32'd0);
        check("rstmid_valid2", {31'd0, bus.rdata_valid}, 32'd0);
        check("rstmid_rdata2", bus.rdata, 32'h0000_0000);
        step();

        // Normal operation resumes after the abandoned access
        run_access(1'b0, 32'h0000_0004, 32'h0, 32'hFEED_FACE, 0, 1'b1, 32'hFEED_FACE, 1'b0, 6'd1, 1'b0, 1'b0);

        step();
        step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
